// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// data_mem_arbiter_if : CPU / aux master ports and data-side memory port
// Revision: 1.0
// ============================================================================
interface data_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic        cpu_valid;
  logic [31:0] cpu_rdata;

  logic        aux_req;
  logic        aux_we;
  logic [10:0] aux_addr;
  logic [31:0] aux_wdata;
  logic        aux_ack;
  logic        aux_valid;
  logic [31:0] aux_rdata;

  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [6:0]  em_addr;
  logic [31:0] em_rdata;

  logic        bus_err;
  logic [15:0] grant_cnt_cpu;
  logic [15:0] grant_cnt_aux;
  logic [15:0] err_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    input  ram_rdata, em_rdata,
    output cpu_ack, cpu_valid, cpu_rdata,
    output aux_ack, aux_valid, aux_rdata,
    output ram_addr, ram_wdata, ram_we, em_addr,
    output bus_err, grant_cnt_cpu, grant_cnt_aux, err_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output aux_req, aux_we, aux_addr, aux_wdata,
    output ram_rdata, em_rdata,
    input  cpu_ack, cpu_valid, cpu_rdata,
    input  aux_ack, aux_valid, aux_rdata,
    input  ram_addr, ram_wdata, ram_we, em_addr,
    input  bus_err, grant_cnt_cpu, grant_cnt_aux, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// data_mem_arbiter : arbitrates CPU and aux masters onto the data RAM / EM port
// Optional statistics counters: define DATA_ARB_STATS_EN.
// Revision: 1.0
// ============================================================================
module data_mem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WCNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RD   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    RG_RAM = 2'd0,
    RG_EM  = 2'd1,
    RG_ERR = 2'd2
  } region_t;

  localparam logic [WCNT_W-1:0] C_MAX_WAIT = WCNT_W'(MAX_WAIT);
  localparam logic              C_PORT_CPU = 1'b0;
  localparam logic              C_PORT_AUX = 1'b1;

  function automatic region_t decode(input logic [10:0] addr);
    region_t rg;
    if (!addr[10])
      rg = RG_RAM;
    else if (addr[9:7] == 3'b000)
      rg = RG_EM;
    else
      rg = RG_ERR;
    return rg;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rd_port;
  region_t           r_rd_region;
  logic [WCNT_W-1:0] r_wait_cnt;

  logic              w_idle;
  logic              w_aux_starved;
  logic              w_grant_cpu;
  logic              w_grant_aux;
  logic              w_grant;
  logic              w_sel_we;
  logic [10:0]       w_sel_addr;
  logic [31:0]       w_sel_wdata;
  region_t           w_sel_region;
  logic              w_wr_grant;
  logic              w_rd_grant;
  logic              w_rd_active;
  logic [31:0]       w_rd_data;

  // --------------------------------------------------------------------------
  // Arbitration: grants are also gated by rst so acks drop the moment reset
  // asserts, independent of the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    w_idle        = (r_state == S_IDLE);
    w_aux_starved = bus.aux_req && (r_wait_cnt >= C_MAX_WAIT);
    w_grant_aux   = rst && w_idle && bus.aux_req && (w_aux_starved || !bus.cpu_req);
    w_grant_cpu   = rst && w_idle && bus.cpu_req && !w_grant_aux;
    w_grant       = w_grant_cpu || w_grant_aux;
  end

  always_comb begin
    w_sel_we     = bus.cpu_we;
    w_sel_addr   = bus.cpu_addr;
    w_sel_wdata  = bus.cpu_wdata;
    if (w_grant_aux) begin
      w_sel_we    = bus.aux_we;
      w_sel_addr  = bus.aux_addr;
      w_sel_wdata = bus.aux_wdata;
    end
    w_sel_region = decode(w_sel_addr);
    w_wr_grant   = w_grant && w_sel_we;
    w_rd_grant   = w_grant && !w_sel_we;
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_rd_grant) w_state_nxt = S_RD;
      S_RD:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Port and region of the in-flight read, used to route data in T+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_port   <= C_PORT_CPU;
      r_rd_region <= RG_RAM;
    end else if (w_rd_grant) begin
      r_rd_port   <= w_grant_aux ? C_PORT_AUX : C_PORT_CPU;
      r_rd_region <= w_sel_region;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_wait_cnt <= '0;
    else if (!bus.aux_req || w_grant_aux)
      r_wait_cnt <= '0;
    else if (r_wait_cnt < C_MAX_WAIT)
      r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  // --------------------------------------------------------------------------
  // Memory port and read return
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_active = (r_state == S_RD);
    case (r_rd_region)
      RG_RAM:  w_rd_data = bus.ram_rdata;
      RG_EM:   w_rd_data = bus.em_rdata;
      default: w_rd_data = 32'h0;
    endcase
  end

  assign bus.ram_addr  = w_sel_addr[9:0];
  assign bus.em_addr   = w_sel_addr[6:0];
  assign bus.ram_wdata = w_sel_wdata;
  assign bus.ram_we    = w_wr_grant && (w_sel_region == RG_RAM);

  assign bus.cpu_ack   = w_grant_cpu;
  assign bus.aux_ack   = w_grant_aux;
  assign bus.cpu_valid = w_rd_active && (r_rd_port == C_PORT_CPU);
  assign bus.aux_valid = w_rd_active && (r_rd_port == C_PORT_AUX);
  assign bus.cpu_rdata = bus.cpu_valid ? w_rd_data : 32'h0;
  assign bus.aux_rdata = bus.aux_valid ? w_rd_data : 32'h0;

  // Errors: dropped write in T, or an unmapped read at data-return time.
  assign bus.bus_err   = (w_wr_grant && (w_sel_region != RG_RAM)) ||
                         (w_rd_active && (r_rd_region == RG_ERR));

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef DATA_ARB_STATS_EN
  logic [15:0] r_grant_cnt_cpu;
  logic [15:0] r_grant_cnt_aux;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant_cnt_cpu <= 16'h0;
      r_grant_cnt_aux <= 16'h0;
      r_err_cnt       <= 16'h0;
    end else begin
      if (w_grant_cpu && (r_grant_cnt_cpu != 16'hFFFF))
        r_grant_cnt_cpu <= r_grant_cnt_cpu + 16'h1;
      if (w_grant_aux && (r_grant_cnt_aux != 16'hFFFF))
        r_grant_cnt_aux <= r_grant_cnt_aux + 16'h1;
      if (bus.bus_err && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'h1;
    end
  end

  assign bus.grant_cnt_cpu = r_grant_cnt_cpu;
  assign bus.grant_cnt_aux = r_grant_cnt_aux;
  assign bus.err_cnt       = r_err_cnt;
`else
  assign bus.grant_cnt_cpu = 16'h0;
  assign bus.grant_cnt_aux = 16'h0;
  assign bus.err_cnt       = 16'h0;
`endif

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Sits between the CPU data port, a second bus master (aux, e.g. message loader/result reader) and the data-side memories: data RAM and the encrypted-message memory (EM).
- Arbitrates the single synchronous RAM/EM port between the two masters.
- Decodes the 11-bit address into RAM, EM or an error region.
- Sequences the 1-cycle synchronous read latency. Replaces the purely combinational chipset select on the data side.

Parameters:
- MAX_WAIT, 4: cycles aux may be denied while requesting before it gets priority over CPU.
- WCNT_W, 3: width of the aux wait counter (must hold MAX_WAIT).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (low = reset)
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  11  CPU byte-free word address
- cpu_wdata  in  32  CPU write data
- cpu_ack  out  1  CPU request accepted this cycle
- cpu_valid  out  1  CPU read data valid
- cpu_rdata  out  32  CPU read data
- aux_req, aux_we, aux_addr[10:0], aux_wdata[31:0]  in  same meaning for aux
- aux_ack, aux_valid, aux_rdata[31:0]  out  same meaning for aux
- ram_addr  out  10  RAM address
- ram_wdata  out  32  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  32  RAM read data, 1-cycle latency
- em_addr  out  7  EM address
- em_rdata  in  32  EM read data, 1-cycle latency
- bus_err  out  1  one-cycle pulse on illegal access
- grant_cnt_cpu, grant_cnt_aux, err_cnt  out  16 each  statistics (see Optional Feature)

Behaviour:
- Address map:
  - addr[10]=0 → RAM; ram_addr = addr[9:0].
  - addr[10]=1 and addr[9:7]=0 → EM (read-only); em_addr = addr[6:0].
  - Everything else → ERR.
- States:
  - IDLE: accepts a new grant.
  - RD: read in flight; latches port id and region.
- Arbitration (IDLE only, combinational):
  - Aux wins if aux_req and wait_cnt ≥ MAX_WAIT.
  - Otherwise CPU wins if cpu_req.
  - Otherwise aux wins if aux_req.
- Grant cycle T:
  - Winner's ack = 1 for exactly that cycle.
  - ram_addr/em_addr/ram_wdata driven combinationally from the winner.
  - The requester holds req/we/addr/wdata stable until it sees ack.
- Write grant:
  - RAM region: ram_we = 1 in cycle T; write commits at the T edge; state stays IDLE, so back-to-back writes run every cycle.
  - EM or ERR region: ram_we = 0, write dropped, bus_err = 1 in T.
- Read grant: state → RD at the end of T. In cycle T+1:
  - Granted port's valid = 1.
  - rdata = ram_rdata (RAM), em_rdata (EM), or 0 (ERR, with bus_err = 1 in T+1).
  - No grant in RD; return to IDLE after T+1.
  - Minimum read-to-next-grant spacing: 2 cycles.
- Idle outputs:
  - rdata holds 0 when valid = 0.
  - ram_we = 0 whenever there is no write grant.
  - Address outputs are don't-care except ram_we gating.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, each cycle aux_req = 1 and aux_ack = 0.
  - Clears on aux_ack or aux_req = 0.
- Simultaneous requests: CPU first unless aux is starved. Each then receives exactly one ack per transaction.
- Reset (rst low, any cycle):
  - Immediately: state = IDLE, wait_cnt = 0, and all acks, valids, ram_we, bus_err and rdata = 0.
  - An in-flight read is discarded with no valid pulse.
  - First grant possible in the first cycle after rst rises.

Optional Feature:
- Macro: DATA_ARB_STATS_EN.
- Defined:
  - grant_cnt_cpu and grant_cnt_aux increment on each ack of their port.
  - err_cnt increments on each bus_err pulse.
  - All are 16-bit, saturate at 0xFFFF and reset to 0.
- Undefined: the three outputs are tied to 0 and no counter registers are built. Arbitration behaviour is identical either way.

Test Plan:
- CPU write 0x0A5 data 0xDEADBEEF, then CPU read 0x0A5 → ram_we = 1 in T only; cpu_ack then cpu_valid one cycle later with 0xDEADBEEF; aux idle.
- CPU read 0x412 with em_rdata = 0x12345678 → em_addr = 0x12; cpu_valid at T+1 with 0x12345678; ram_we = 0.
- CPU write 0x412 and CPU read 0x600 → write: bus_err in T, ram_we = 0. Read: cpu_valid with 0x00000000 and bus_err at T+1. With macro defined, err_cnt = 2.
- cpu_req continuous writes plus aux_req read held from cycle 0, MAX_WAIT = 4 → CPU acked cycles 0–3; aux_ack at cycle 4; aux_valid at cycle 5; CPU re-acked at cycle 6.
- Both request reads at once, no starvation → cpu_ack at T, cpu_valid at T+1, aux_ack at T+2, aux_valid at T+3.
- rst driven low during the RD cycle of an aux read → aux_valid never pulses; all outputs 0 immediately; a new CPU request is acked in the first cycle after rst releases.
